// File: rtl/cr16_regfile_pkg.sv
// Shared definitions for the CompactRISC16 register file: default geometry and write modes.
package cr16_regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        WmodeWord = 2'b00,
        WmodeLo   = 2'b01,
        WmodeHi   = 2'b10,
        WmodeLui  = 2'b11
    } wmode_e;

endpackage

// File: rtl/cr16_wmerge.sv
// Combines the old register value with write data according to the write mode.
module cr16_wmerge
    import cr16_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] old_value,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  wmode_e                wmode,
    output logic [DATA_WIDTH-1:0] merged
);

    localparam int unsigned H = DATA_WIDTH / 2;

    always_comb begin
        merged = wdata;
        unique case (wmode)
            WmodeWord: merged = wdata;
            WmodeLo:   merged = {old_value[DATA_WIDTH-1:H], wdata[H-1:0]};
            // High-byte and LUI both take their byte from the low lane of the write data.
            WmodeHi:   merged = {wdata[H-1:0], old_value[H-1:0]};
            WmodeLui:  merged = {wdata[H-1:0], {H{1'b0}}};
        endcase
    end

endmodule

// File: rtl/cr16_regfile.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file with two registered, write-first read ports.
module cr16_regfile
    import cr16_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET,
    input  logic                  I_WE,
    input  logic [1:0]            I_WMODE,
    input  logic [ADDR_WIDTH-1:0] I_WADDR,
    input  logic [DATA_WIDTH-1:0] I_WDATA,
    input  logic                  I_REN_A,
    input  logic [ADDR_WIDTH-1:0] I_RADDR_A,
    output logic [DATA_WIDTH-1:0] O_RDATA_A,
    input  logic                  I_REN_B,
    input  logic [ADDR_WIDTH-1:0] I_RADDR_B,
    output logic [DATA_WIDTH-1:0] O_RDATA_B
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  fwd_a;
    logic                  fwd_b;

    // One merge unit feeds the storage write and both forwarding paths.
    cr16_wmerge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wmerge (
        .old_value(regs_q[I_WADDR]),
        .wdata    (I_WDATA),
        .wmode    (wmode_e'(I_WMODE)),
        .merged   (merged)
    );

    assign fwd_a = I_WE && (I_RADDR_A == I_WADDR);
    assign fwd_b = I_WE && (I_RADDR_B == I_WADDR);

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (I_WE) begin
                regs_q[I_WADDR] <= merged;
            end
            if (I_REN_A) begin
                rdata_a_q <= fwd_a ? merged : regs_q[I_RADDR_A];
            end
            if (I_REN_B) begin
                rdata_b_q <= fwd_b ? merged : regs_q[I_RADDR_B];
            end
        end
    end

    assign O_RDATA_A = rdata_a_q;
    assign O_RDATA_B = rdata_b_q;

endmodule

// File: tb/tb_cr16_regfile.sv
// Directed self-checking bench for cr16_regfile with hand-computed expectations.
module tb_cr16_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [1:0]  wmode = 2'b00;
    logic [3:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic        ren_a = 1'b0;
    logic [3:0]  raddr_a = '0;
    logic [15:0] rdata_a;
    logic        ren_b = 1'b0;
    logic [3:0]  raddr_b = '0;
    logic [15:0] rdata_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cr16_regfile dut (
        .I_CLK    (clk),
        .I_RESET  (rst),
        .I_WE     (we),
        .I_WMODE  (wmode),
        .I_WADDR  (waddr),
        .I_WDATA  (wdata),
        .I_REN_A  (ren_a),
        .I_RADDR_A(raddr_a),
        .O_RDATA_A(rdata_a),
        .I_REN_B  (ren_b),
        .I_RADDR_B(raddr_b),
        .O_RDATA_B(rdata_b)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic en, input logic [1:0] m, input logic [3:0] a,
                             input logic [15:0] d);
        we = en;
        wmode = m;
        waddr = a;
        wdata = d;
    endtask

    task automatic set_read(input logic ea, input logic [3:0] aa, input logic eb,
                            input logic [3:0] ab);
        ren_a = ea;
        raddr_a = aa;
        ren_b = eb;
        raddr_b = ab;
    endtask

    initial begin
        #1;
        tick();
        rst = 1'b0;

        // Reset clears storage and outputs
        set_write(1'b1, 2'b00, 4'd5, 16'hBEEF);
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b1, 4'd5, 1'b1, 4'd5);
        tick();
        check_eq("pre_reset_r5_a", rdata_a, 16'hBEEF);
        rst = 1'b1;
        tick();
        check_eq("reset_cycle_a", rdata_a, 16'h0000);
        check_eq("reset_cycle_b", rdata_b, 16'h0000);
        rst = 1'b0;
        tick();
        check_eq("post_reset_r5_a", rdata_a, 16'h0000);
        check_eq("post_reset_r5_b", rdata_b, 16'h0000);

        // Word write, then one-cycle read latency
        set_write(1'b1, 2'b00, 4'd3, 16'h1234);
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b1, 4'd3, 1'b1, 4'd0);
        tick();
        check_eq("word_r3_a", rdata_a, 16'h1234);
        check_eq("word_r0_b", rdata_b, 16'h0000);

        // Register 0 is writable
        set_write(1'b1, 2'b00, 4'd0, 16'hABCD);
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b0, 4'd0, 1'b1, 4'd0);
        tick();
        check_eq("r0_writable_b", rdata_b, 16'hABCD);

        // Byte modes on r7
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        set_write(1'b1, 2'b00, 4'd7, 16'hAABB);
        tick();
        set_write(1'b1, 2'b01, 4'd7, 16'h3311);
        tick();
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b1, 4'd7, 1'b1, 4'd7);
        tick();
        check_eq("lo_byte_a", rdata_a, 16'hAA11);
        check_eq("lo_byte_b", rdata_b, 16'hAA11);
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        set_write(1'b1, 2'b10, 4'd7, 16'h9922);
        tick();
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b1, 4'd7, 1'b0, 4'd0);
        tick();
        check_eq("hi_byte_a", rdata_a, 16'h2211);
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        set_write(1'b1, 2'b11, 4'd7, 16'h775C);
        tick();
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b0, 4'd0, 1'b1, 4'd7);
        tick();
        check_eq("lui_b", rdata_b, 16'h5C00);

        // Write-first forwarding of a high-byte write
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        set_write(1'b1, 2'b00, 4'd2, 16'h00FF);
        tick();
        set_write(1'b1, 2'b10, 4'd2, 16'h0080);
        set_read(1'b1, 4'd2, 1'b1, 4'd2);
        tick();
        check_eq("fwd_hi_a", rdata_a, 16'h80FF);
        check_eq("fwd_hi_b", rdata_b, 16'h80FF);

        // Forwarding of low-byte and LUI writes, split across ports
        set_write(1'b1, 2'b01, 4'd2, 16'hEE42);
        set_read(1'b1, 4'd2, 1'b1, 4'd3);
        tick();
        check_eq("fwd_lo_a", rdata_a, 16'h8042);
        check_eq("no_fwd_b", rdata_b, 16'h1234);
        set_write(1'b1, 2'b11, 4'd2, 16'h0137);
        set_read(1'b1, 4'd3, 1'b1, 4'd2);
        tick();
        check_eq("fwd_lui_b", rdata_b, 16'h3700);
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b1, 4'd2, 1'b0, 4'd0);
        tick();
        check_eq("stored_lui_a", rdata_a, 16'h3700);

        // Stall hold on port A
        set_read(1'b1, 4'd3, 1'b0, 4'd0);
        tick();
        check_eq("stall_pre_a", rdata_a, 16'h1234);
        ren_a = 1'b0;
        set_write(1'b1, 2'b00, 4'd3, 16'h9999);
        tick();
        check_eq("stall_hold1_a", rdata_a, 16'h1234);
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        tick();
        check_eq("stall_hold2_a", rdata_a, 16'h1234);
        ren_a = 1'b1;
        tick();
        check_eq("stall_release_a", rdata_a, 16'h9999);

        // Reset beats an in-flight write
        set_read(1'b0, 4'd0, 1'b0, 4'd0);
        set_write(1'b1, 2'b00, 4'd4, 16'h1111);
        tick();
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        set_read(1'b1, 4'd4, 1'b0, 4'd0);
        tick();
        check_eq("r4_before_a", rdata_a, 16'h1111);
        rst = 1'b1;
        set_write(1'b1, 2'b00, 4'd4, 16'hFFFF);
        set_read(1'b1, 4'd4, 1'b1, 4'd4);
        tick();
        check_eq("rst_prio_cycle_a", rdata_a, 16'h0000);
        rst = 1'b0;
        set_write(1'b0, 2'b00, 4'd0, 16'h0000);
        tick();
        check_eq("rst_prio_r4_a", rdata_a, 16'h0000);
        check_eq("rst_prio_r4_b", rdata_b, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
